// File: rtl/sc_stage_scheduler.sv
// sc_stage_scheduler: depth-first f/g stage sequencer for the polar SC decoder PE array (optional SC_SCHED_PERF_EN adds cyc_cnt)
module sc_stage_scheduler #(
  parameter int MAX_LOG_N = 9,
  parameter int PE_LOG = 6,
  parameter int STG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           n_log,
  output logic                 pe_en,
  output logic                 pe_fg,
  output logic [STG_W-1:0]     pe_stage,
  output logic [MAX_LOG_N-1:0] pe_grp,
  output logic                 pe_last,
  output logic [MAX_LOG_N-1:0] leaf_idx,
  output logic                 leaf_valid,
  input  logic                 leaf_ack,
  output logic                 busy,
  output logic                 done
`ifdef SC_SCHED_PERF_EN
  ,
  output logic [15:0]          cyc_cnt
`endif
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STAGE = 3'd2, LEAF = 3'd3, DONE = 3'd4;
  logic [2:0] state, nxt_state;
  logic [3:0] n, n_clamp;
  logic [MAX_LOG_N:0] n_max;
  logic [MAX_LOG_N-1:0] nxt_i, nxt_grp, last_grp, nxt_last_grp;
  logic [STG_W-1:0] nxt_s;
  logic nxt_fg, is_last_leaf;
  function automatic logic [MAX_LOG_N-1:0] grp_m1(input logic [STG_W-1:0] s);
    return (int'(s) > PE_LOG) ? MAX_LOG_N'((1 << (int'(s) - PE_LOG)) - 1) : '0;
  endfunction
  function automatic logic [STG_W-1:0] ctz(input logic [MAX_LOG_N-1:0] v);
    logic [STG_W-1:0] k;
    k = '0;
    for (int b = MAX_LOG_N - 1; b >= 0; b--)
      if (v[b]) k = STG_W'(b);
    return k;
  endfunction
  assign n_clamp = n_log == 4'd0 ? 4'd1 : (n_log > 4'(MAX_LOG_N) ? 4'(MAX_LOG_N) : n_log);
  assign n_max = (MAX_LOG_N + 1)'((1 << n) - 1);
  assign is_last_leaf = {1'b0, leaf_idx} == n_max;
  assign last_grp = grp_m1(pe_stage);
  assign nxt_last_grp = grp_m1(nxt_s);
  // pe_fg/pe_stage/pe_grp double as the op state; they only matter while pe_en is high
  always_comb begin
    nxt_state = state;
    nxt_i = leaf_idx;
    nxt_fg = pe_fg;
    nxt_s = pe_stage;
    nxt_grp = pe_grp;
    case (state)
      IDLE: if (start) begin
        nxt_state = LOAD;
        nxt_i = '0;
      end
      LOAD: begin
        nxt_state = STAGE;
        nxt_grp = '0;
        nxt_fg = leaf_idx != '0;
        nxt_s = leaf_idx == '0 ? STG_W'(n - 4'd1) : ctz(leaf_idx);
      end
      STAGE: if (pe_grp != last_grp) nxt_grp = pe_grp + 1'b1;
      else if (pe_stage != '0) begin
        nxt_fg = 1'b0;
        nxt_s = pe_stage - 1'b1;
        nxt_grp = '0;
      end else nxt_state = LEAF;
      LEAF: if (leaf_ack) begin
        nxt_state = is_last_leaf ? DONE : LOAD;
        nxt_i = is_last_leaf ? leaf_idx : leaf_idx + 1'b1;
      end
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= 4'd1;
      leaf_idx <= '0;
      pe_fg <= 1'b0;
      pe_stage <= '0;
      pe_grp <= '0;
      pe_en <= 1'b0;
      pe_last <= 1'b0;
      leaf_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && start) n <= n_clamp;
      leaf_idx <= nxt_i;
      pe_fg <= nxt_fg;
      pe_stage <= nxt_s;
      pe_grp <= nxt_grp;
      pe_en <= nxt_state == STAGE;
      pe_last <= nxt_state == STAGE && nxt_grp == nxt_last_grp;
      leaf_valid <= nxt_state == LEAF;
      busy <= nxt_state != IDLE;
      done <= nxt_state == DONE;
    end
  end
`ifdef SC_SCHED_PERF_EN
  // counts the cycle being entered, so the DONE cycle already shows the full total
  always_ff @(posedge clk) begin
    if (rst) cyc_cnt <= '0;
    else if (state == IDLE && start) cyc_cnt <= 16'd1;
    else if (state != IDLE && nxt_state != IDLE && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sc_stage_scheduler.sv
// tb_sc_stage_scheduler: vector table + random-ack runs checked against a tree-walk model of the schedule
module tb_sc_stage_scheduler;
  logic clk = 0, rst = 1, start = 0, ack = 0, sel = 0;
  logic [3:0] n_log = 0;
  logic a_en, a_fg, a_last, a_lv, a_busy, a_done;
  logic [3:0] a_stage;
  logic [2:0] a_grp, a_idx;
  logic b_en, b_fg, b_last, b_lv, b_busy, b_done;
  logic [3:0] b_stage;
  logic [8:0] b_grp, b_idx;
  logic o_en, o_fg, o_last, o_lv, o_busy, o_done;
  logic [3:0] o_stage;
  logic [8:0] o_grp, o_idx;
  int obs, pass_cnt = 0, tot_cnt = 0;
`ifdef SC_SCHED_PERF_EN
  logic [15:0] a_cyc, b_cyc, o_cyc;
  assign o_cyc = sel ? b_cyc : a_cyc;
`endif
  always #5 clk = ~clk;
  sc_stage_scheduler #(.MAX_LOG_N(3), .PE_LOG(1), .STG_W(4)) u_small (
    .clk(clk), .rst(rst), .start(start && !sel), .n_log(n_log),
    .pe_en(a_en), .pe_fg(a_fg), .pe_stage(a_stage), .pe_grp(a_grp), .pe_last(a_last),
    .leaf_idx(a_idx), .leaf_valid(a_lv), .leaf_ack(ack && !sel), .busy(a_busy), .done(a_done)
`ifdef SC_SCHED_PERF_EN
    , .cyc_cnt(a_cyc)
`endif
  );
  sc_stage_scheduler #(.MAX_LOG_N(9), .PE_LOG(6), .STG_W(4)) u_big (
    .clk(clk), .rst(rst), .start(start && sel), .n_log(n_log),
    .pe_en(b_en), .pe_fg(b_fg), .pe_stage(b_stage), .pe_grp(b_grp), .pe_last(b_last),
    .leaf_idx(b_idx), .leaf_valid(b_lv), .leaf_ack(ack && sel), .busy(b_busy), .done(b_done)
`ifdef SC_SCHED_PERF_EN
    , .cyc_cnt(b_cyc)
`endif
  );
  assign o_en = sel ? b_en : a_en;
  assign o_fg = sel ? b_fg : a_fg;
  assign o_last = sel ? b_last : a_last;
  assign o_lv = sel ? b_lv : a_lv;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_stage = sel ? b_stage : a_stage;
  assign o_grp = sel ? b_grp : 9'(a_grp);
  assign o_idx = sel ? b_idx : 9'(a_idx);
  function automatic int mk(int lv, int en, int fg, int last, int bsy, int dn, int s, int grp, int idx);
    return (lv << 27) | (en << 26) | (fg << 25) | (last << 24) | (bsy << 23) | (dn << 22) | (s << 18) | (grp << 9) | idx;
  endfunction
  always_comb obs = mk(int'(o_lv), int'(o_en), int'(o_fg), int'(o_last), int'(o_busy), int'(o_done),
                       int'(o_stage), int'(o_grp), int'(o_idx));
  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  typedef struct { int i; int fg; int s; int grp; int last; } op_t;
  op_t exp_q[$];
  // expected STAGE cycles: leaf i walks stages ctz(i)..0 (leaf 0: n-1..0), first op g except leaf 0
  task automatic build(input int nn, input int pl);
    exp_q.delete();
    for (int i = 0; i < (1 << nn); i++) begin
      int top, fg;
      if (i == 0) begin top = nn - 1; fg = 0; end
      else begin top = 0; while (((i >> top) & 1) == 0) top++; fg = 1; end
      for (int s = top; s >= 0; s--) begin
        int g = (1 << s) >> pl;
        if (g == 0) g = 1;
        for (int j = 0; j < g; j++) exp_q.push_back('{i, fg, s, j, int'(j == g - 1)});
        fg = 0;
      end
    end
  endtask
  typedef struct { bit sel; int n; bit rnd; int slow; int exp_stage; int exp_leaves; int cyc; } vec_t;
  vec_t vecs[8];
  task automatic run(input vec_t v);
    int nn, mx, stage_n = 0, leaves = 0, busy_n = 0, exp_leaf = 0, hold = 0, want = 1, cyc = 0;
    bit in_leaf = 0, fin = 0;
    op_t e;
    sel = v.sel;
    mx = v.sel ? 9 : 3;
    nn = v.n == 0 ? 1 : (v.n > mx ? mx : v.n);
    build(nn, v.sel ? 6 : 1);
    @(negedge clk);
    n_log = 4'(v.n);
    start = 1;
    ack = v.rnd ? 1'($urandom % 2) : 1'b1;
    @(negedge clk);
    start = 0;
    while (!fin && cyc < 20000) begin
      cyc++;
      start = 0;
      if (o_busy) busy_n++;
      if (o_en) begin
        stage_n++;
        if (exp_q.size() == 0) chk("stage_extra", obs, 0);
        else begin
          e = exp_q.pop_front();
          chk("stage_op", obs, mk(0, 1, e.fg, e.last, 1, 0, e.s, e.grp, e.i));
        end
        if (v.rnd && (stage_n == 1 || $urandom % 4 == 0)) begin start = 1; n_log = 4'($urandom); end
      end
      if (o_lv) begin
        if (!in_leaf) begin
          in_leaf = 1; hold = 0; leaves++;
          want = exp_leaf == v.slow ? 5 : (v.rnd ? int'($urandom_range(1, 3)) : 1);
        end
        hold++;
        chk("leaf_idx", int'(o_idx) | (int'(o_en) << 9), exp_leaf);
        ack = hold >= want;
      end else begin
        if (in_leaf) begin chk("leaf_hold", hold, want); in_leaf = 0; exp_leaf++; end
        ack = v.rnd ? 1'($urandom % 2) : 1'b1;
      end
      if (o_done) fin = 1;
      @(negedge clk);
    end
    ack = 0;
    chk("done_seen", int'(fin), 1);
    chk("idle_after", {o_busy, o_done, o_en, o_lv}, 0);
    chk("stage_cycles", stage_n, v.exp_stage);
    chk("leaves", leaves, v.exp_leaves);
    chk("model_left", exp_q.size(), 0);
    if (v.cyc != 0) chk("busy_cycles", busy_n, v.cyc);
`ifdef SC_SCHED_PERF_EN
    chk("cyc_cnt", int'(o_cyc), busy_n);
    if (v.cyc != 0) chk("cyc_cnt_exp", int'(o_cyc), v.cyc);
`endif
  endtask
  initial begin
    int cnt;
    bit seen;
    vecs[0] = '{0, 3, 0, -1, 16, 8, 33};
    vecs[1] = '{0, 3, 0, 3, 16, 8, 37};
    vecs[2] = '{0, 0, 1, -1, 2, 2, 0};
    vecs[3] = '{0, 7, 1, -1, 16, 8, 0};
    vecs[4] = '{0, 2, 1, -1, 6, 4, 0};
    vecs[5] = '{1, 9, 1, -1, 1032, 512, 0};
    vecs[6] = '{1, 3, 0, -1, 14, 8, 31};
    vecs[7] = '{0, 1, 0, -1, 2, 2, 7};
    repeat (3) @(negedge clk);
    rst = 0;
    sel = 0;
    chk("reset_small", obs, 0);
    sel = 1;
    #1 chk("reset_big", obs, 0);
    for (int k = 0; k < 8; k++) run(vecs[k]);
    sel = 0;
    ack = 1;
    @(negedge clk);
    n_log = 4'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    cnt = 0;
    while (!(o_en && o_idx == 9'd5) && cnt < 200) begin @(negedge clk); cnt++; end
    chk("reach_leaf5", int'(cnt < 200), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid", obs, 0);
    seen = 0;
    repeat (6) begin @(negedge clk); if (o_done || o_busy) seen = 1; end
    chk("no_done_after_rst", int'(seen), 0);
    run(vecs[0]);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
